elastic_buffer_flushable: RTL and testbench
===========================================

ELASTIC_BUFFER_FLUSHABLE -- requirements
Module: elastic_buffer_flushable

Interface
REQ-001 SHALL have parameter DataWidth, default 32, bit width of each beat.
REQ-002 SHALL have parameter Depth, default 2, number of storage entries; legal range 2..64.
REQ-003 SHALL have parameter Bypass, default 0; 1 makes the block transparent (valid_o=valid_i, ready_o=ready_i, data_o=data_i, usage_o=0).
REQ-004 clk_i  input  1  single clock, all state updates on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 clr_i  input  1  synchronous clear, empties buffer and zeroes stored data.
REQ-007 flush_i  input  1  synchronous flush, discards all stored beats.
REQ-008 valid_i  input  1  upstream beat valid.
REQ-009 ready_o  output  1  buffer can accept a beat.
REQ-010 data_i  input  DataWidth  upstream beat.
REQ-011 valid_o  output  1  downstream beat valid.
REQ-012 ready_i  input  1  downstream accepts beat.
REQ-013 data_o  output  DataWidth  oldest stored beat.
REQ-014 usage_o  output  $clog2(Depth+1)  number of stored beats.

Function
REQ-015 SHALL store beats FIFO-ordered in a Depth-entry circular buffer with read/write pointers wrapping from Depth-1 to 0 (Depth need not be a power of two).
REQ-016 ready_o SHALL be derived from registered state only: ready_o = (usage < Depth); no combinational path from ready_i.
REQ-017 valid_o, data_o, usage_o SHALL be derived from registered state only; no combinational path from valid_i or data_i.
REQ-018 Input handshake: valid_i && ready_o && !flush_i && !clr_i writes data_i at write pointer; pointer and usage update at the edge.
REQ-019 Output handshake: valid_o && ready_i && !flush_i && !clr_i pops the entry at read pointer.
REQ-020 Latency SHALL be exactly one cycle: a beat accepted into an empty buffer appears on valid_o/data_o in the next cycle.
REQ-021 Simultaneous push and pop when full SHALL not occur (ready_o=0); simultaneous push and pop when not full SHALL keep usage unchanged; Depth>=2 SHALL sustain one beat per cycle.
REQ-022 When empty, valid_o SHALL be 0 and data_o SHALL hold its last value (not required to be zero).
REQ-023 flush_i SHALL set usage to 0 and both pointers to 0 at the next edge; stored data registers retain contents; any beat offered on valid_i in the same cycle SHALL be discarded, not stored.
REQ-024 Any downstream handshake coinciding with flush_i SHALL be treated as not having occurred from the buffer's perspective; downstream designs must not rely on it.
REQ-025 clr_i SHALL behave as flush_i and additionally reset all data entries to 0; clr_i takes precedence over flush_i.

Reset
REQ-026 On rst_ni low, asynchronously: usage_o=0, pointers=0, valid_o=0, ready_o=1, data entries=0, data_o=0.
REQ-027 Reset asserted mid-transfer SHALL drop all stored beats; first valid_o after reset requires a new input handshake.

Configuration
REQ-028 Macro ELASTIC_BUFFER_FLUSH_STATS_EN defined: SHALL add output drop_cnt_o (16 bits, reset 0, cleared by clr_i) counting beats discarded by flush_i (stored usage plus one if valid_i was high), saturating at 16'hFFFF.
REQ-029 Macro undefined: drop_cnt_o and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Depth=4, ready_i=0, push A,B,C,D -> ready_o=0 after 4th beat, usage_o=4; then ready_i=1 -> A,B,C,D out in order on consecutive cycles.
REQ-031 Depth=2, valid_i=1 and ready_i=1 continuously with beats 0..99 -> after 1-cycle latency, one beat per cycle, no bubbles, order preserved.
REQ-032 Depth=3, wrap-around: 10 push/pop rounds with usage oscillating 0..3 -> data order correct across pointer wrap 2->0.
REQ-033 Usage 3, flush_i=1 with valid_i=1 -> next cycle usage_o=0, valid_o=0, ready_o=1; with STATS macro drop_cnt_o increments by 4.
REQ-034 Usage 2, assert rst_ni low between clock edges -> valid_o=0, usage_o=0, data_o=0 immediately, before next edge.
REQ-035 Bypass=1 -> valid_o, ready_o, data_o track inputs combinationally in the same cycle; usage_o=0.

Source files
------------

// File: rtl/elastic_buffer_flushable.sv
// Flushable elastic buffer: Depth-entry circular FIFO with registered-only handshake outputs.
// Optional drop statistics enabled by defining ELASTIC_BUFFER_FLUSH_STATS_EN.
module elastic_buffer_flushable #(
    parameter int DataWidth = 32,
    parameter int Depth     = 2,
    parameter bit Bypass    = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DataWidth-1:0]       data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DataWidth-1:0]       data_o,
    output logic [$clog2(Depth+1)-1:0] usage_o
`ifdef ELASTIC_BUFFER_FLUSH_STATS_EN
    ,
    output logic [15:0]                drop_cnt_o
`endif
);

    localparam int UsageW = $clog2(Depth + 1);
    localparam int PtrW   = $clog2(Depth);

    // Pointers wrap explicitly so non power-of-two depths stay in range.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [UsageW:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    if (Bypass) begin : g_bypass
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
        assign usage_o = '0;
`ifdef ELASTIC_BUFFER_FLUSH_STATS_EN
        assign drop_cnt_o = '0;
`endif
    end else begin : g_buffer
        logic [DataWidth-1:0] mem_p0 [Depth];
        logic [PtrW-1:0]      rd_ptr_p0;
        logic [PtrW-1:0]      wr_ptr_p0;
        logic [UsageW-1:0]    usage_p0;
        logic                 vld_p0;
        logic                 push;
        logic                 pop;

        assign vld_p0  = (usage_p0 != '0);
        assign ready_o = (usage_p0 != UsageW'(Depth));
        assign valid_o = vld_p0;
        assign data_o  = mem_p0[rd_ptr_p0];
        assign usage_o = usage_p0;

        // A flush or clear in the same cycle swallows both handshakes.
        assign push = valid_i && ready_o && !flush_i && !clr_i;
        assign pop  = vld_p0 && ready_i && !flush_i && !clr_i;

        // ---- storage stage p0: control state ----
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr_p0 <= '0;
                wr_ptr_p0 <= '0;
                usage_p0  <= '0;
            end else if (clr_i || flush_i) begin
                rd_ptr_p0 <= '0;
                wr_ptr_p0 <= '0;
                usage_p0  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_p0 <= ptr_inc(wr_ptr_p0);
                end
                if (pop) begin
                    rd_ptr_p0 <= ptr_inc(rd_ptr_p0);
                end
                if (push && !pop) begin
                    usage_p0 <= usage_p0 + UsageW'(1);
                end else if (pop && !push) begin
                    usage_p0 <= usage_p0 - UsageW'(1);
                end
            end
        end

        // ---- storage stage p0: data entries (flush keeps contents, clear zeroes) ----
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < Depth; i++) begin
                    mem_p0[i] <= '0;
                end
            end else if (clr_i) begin
                for (int i = 0; i < Depth; i++) begin
                    mem_p0[i] <= '0;
                end
            end else if (push) begin
                mem_p0[wr_ptr_p0] <= data_i;
            end
        end

`ifdef ELASTIC_BUFFER_FLUSH_STATS_EN
        logic [15:0] drop_cnt_p0;

        // Every stored beat plus any beat offered during the flush is lost.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                drop_cnt_p0 <= '0;
            end else if (clr_i) begin
                drop_cnt_p0 <= '0;
            end else if (flush_i) begin
                drop_cnt_p0 <= sat_add16(drop_cnt_p0,
                                         {1'b0, usage_p0} + (UsageW + 1)'(valid_i));
            end
        end

        assign drop_cnt_o = drop_cnt_p0;
`endif
    end

endmodule

// File: tb/tb_elastic_buffer_flushable.sv
// Scoreboard bench: three buffer depths under random traffic plus a bypass instance.
`timescale 1ns/1ps
module tb_elastic_buffer_flushable;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int D  = g + 2;
        localparam int UW = $clog2(D + 1);

        logic          rst_n, clr, flush, valid_i, ready_i, ready_o, valid_o;
        logic [DW-1:0] data_i, data_o;
        logic [UW-1:0] usage_o;
        logic [DW-1:0] model_q[$];
        logic [DW-1:0] exp_q[$];
        int            drop_model;
`ifdef ELASTIC_BUFFER_FLUSH_STATS_EN
        logic [15:0]   drop_cnt;
`endif

        elastic_buffer_flushable #(.DataWidth(DW), .Depth(D), .Bypass(1'b0)) dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .clr_i   (clr),
            .flush_i (flush),
            .valid_i (valid_i),
            .ready_o (ready_o),
            .data_i  (data_i),
            .valid_o (valid_o),
            .ready_i (ready_i),
            .data_o  (data_o),
            .usage_o (usage_o)
`ifdef ELASTIC_BUFFER_FLUSH_STATS_EN
            ,
            .drop_cnt_o (drop_cnt)
`endif
        );

        task automatic state_chk();
            chk($sformatf("D%0d_usage", D), 64'(usage_o), 64'(model_q.size()));
            chk($sformatf("D%0d_valid", D), 64'(valid_o), 64'(model_q.size() > 0));
            chk($sformatf("D%0d_ready", D), 64'(ready_o), 64'(model_q.size() < D));
            if (model_q.size() > 0)
                chk($sformatf("D%0d_head", D), 64'(data_o), 64'(model_q[0]));
`ifdef ELASTIC_BUFFER_FLUSH_STATS_EN
            chk($sformatf("D%0d_drops", D), 64'(drop_cnt), 64'(drop_model));
`endif
        endtask

        // One cycle: check the state left by the last edge, then apply inputs to the model.
        task automatic step(input logic v, input logic r, input logic fl, input logic cl,
                            input logic [DW-1:0] d);
            bit push, pop;
            @(negedge clk);
            state_chk();
            valid_i = v; ready_i = r; flush = fl; clr = cl; data_i = d;
            if (cl) drop_model = 0;
            else if (fl) drop_model = (drop_model + model_q.size() + int'(v) > 65535) ?
                                      65535 : drop_model + model_q.size() + int'(v);
            if (cl || fl) begin
                model_q.delete();
            end else begin
                pop  = r && (model_q.size() > 0);
                push = v && (model_q.size() < D);
                if (pop) exp_q.push_back(model_q.pop_front());
                if (push) model_q.push_back(d);
            end
        endtask

        initial begin
            forever begin
                @(negedge clk);
                #4;
                if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i && !flush && !clr) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL D%0d_unexpected_beat: got 0x%0h expected none", D, data_o);
                    end else begin
                        chk($sformatf("D%0d_out_data", D), 64'(data_o), 64'(exp_q.pop_front()));
                    end
                end
            end
        end

        initial begin
            rst_n = 1'b0; clr = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
            data_i = '0; drop_model = 0;
            #12;
            chk($sformatf("D%0d_rst_usage", D), 64'(usage_o), 64'(0));
            chk($sformatf("D%0d_rst_valid", D), 64'(valid_o), 64'(0));
            chk($sformatf("D%0d_rst_ready", D), 64'(ready_o), 64'(1));
            chk($sformatf("D%0d_rst_data", D), 64'(data_o), 64'(0));
            @(negedge clk);
            rst_n = 1'b1;

            // Fill with downstream stalled, then drain in order.
            for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(32'hA0 + i));
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD);
            for (int i = 0; i < D + 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);

            // Continuous streaming.
            for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'b0, DW'(i));
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);

            // Flush a full buffer with a beat offered in the same cycle.
            for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
            step(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);

            for (int i = 0; i < 1500; i++) begin
                int r;
                r = $urandom_range(99);
                step($urandom_range(99) < 60, $urandom_range(99) < 55, r < 3, r == 3, $urandom);
            end

            for (int i = 0; i < D + 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk($sformatf("D%0d_drain_pending", D), 64'(exp_q.size()), 64'(0));

            // Asynchronous reset with two beats stored.
            step(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
            step(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            #2;
            rst_n = 1'b0;
            #1;
            chk($sformatf("D%0d_arst_usage", D), 64'(usage_o), 64'(0));
            chk($sformatf("D%0d_arst_valid", D), 64'(valid_o), 64'(0));
            chk($sformatf("D%0d_arst_data", D), 64'(data_o), 64'(0));
            chk($sformatf("D%0d_arst_ready", D), 64'(ready_o), 64'(1));
            model_q.delete();
            drop_model = 0;
            @(negedge clk);
            rst_n = 1'b1;
            step(1'b0, 1'b1, 1'b0, 1'b0, '0);
            step(1'b0, 1'b1, 1'b0, 1'b0, '0);
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk($sformatf("D%0d_final_pending", D), 64'(exp_q.size()), 64'(0));
            done_cnt++;
        end
    end

    logic          b_valid_i, b_ready_i, b_valid_o, b_ready_o;
    logic [DW-1:0] b_data_i, b_data_o;
    logic [1:0]    b_usage;
`ifdef ELASTIC_BUFFER_FLUSH_STATS_EN
    logic [15:0]   b_drop;
`endif

    elastic_buffer_flushable #(.DataWidth(DW), .Depth(2), .Bypass(1'b1)) dut_byp (
        .clk_i   (clk),
        .rst_ni  (1'b1),
        .clr_i   (1'b0),
        .flush_i (1'b0),
        .valid_i (b_valid_i),
        .ready_o (b_ready_o),
        .data_i  (b_data_i),
        .valid_o (b_valid_o),
        .ready_i (b_ready_i),
        .data_o  (b_data_o),
        .usage_o (b_usage)
`ifdef ELASTIC_BUFFER_FLUSH_STATS_EN
        ,
        .drop_cnt_o (b_drop)
`endif
    );

    initial begin
        b_valid_i = 1'b0; b_ready_i = 1'b0; b_data_i = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b_valid_i = 1'($urandom);
            b_ready_i = 1'($urandom);
            b_data_i  = $urandom;
            #1;
            chk("byp_valid", 64'(b_valid_o), 64'(b_valid_i));
            chk("byp_ready", 64'(b_ready_o), 64'(b_ready_i));
            chk("byp_data", 64'(b_data_o), 64'(b_data_i));
            chk("byp_usage", 64'(b_usage), 64'(0));
        end
        done_cnt++;
    end

    initial begin
        int waited;
        waited = 0;
        while (done_cnt < 4 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        if (done_cnt < 4) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got %0d finished processes expected 4", done_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
